// File: rtl/spi_slave_rx.sv
// SPI responder: oversamples sclk/ss_n/mosi on clk, recovers MSB-first bytes, drives miso.
// Optional macro SPI_SLAVE_OVERRUN_EN enables the sticky overrun flag.
module spi_slave_rx #(
    parameter int DAISY       = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode,
    input  logic       sclk,
    input  logic       ss_n,
    input  logic       mosi,
    output logic       miso,
    input  logic [7:0] tx_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       busy,
    output logic       overrun
);

    typedef enum logic {IDLE, SHIFT} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_hist_q, sclk_hist_d;
    logic                   ss_hist_q, ss_hist_d;
    state_t                 state_q, state_d;
    logic [7:0]             shreg_q, shreg_d;
    logic [7:0]             rxbuf_q, rxbuf_d;
    logic [7:0]             rx_data_q, rx_data_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic                   first_q, first_d;
    logic                   reload_q, reload_d;
    logic                   done_q, done_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   miso_q, miso_d;
    logic                   busy_q, busy_d;
    logic                   overrun_q, overrun_d;

    logic cpol, cpha, sclk_s, ss_s, mosi_s;
    logic lead, trail, sample_edge, shift_edge, ss_fall, ss_rise;

    assign cpol        = mode[1];
    assign cpha        = mode[0];
    assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
    assign ss_s        = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
    assign lead        = (sclk_hist_q == cpol) && (sclk_s != cpol);
    assign trail       = (sclk_hist_q != cpol) && (sclk_s == cpol);
    assign sample_edge = cpha ? trail : lead;
    assign shift_edge  = cpha ? lead : trail;
    assign ss_fall     = ss_hist_q && !ss_s;
    assign ss_rise     = !ss_hist_q && ss_s;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], ss_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        sclk_hist_d = sclk_s;
        ss_hist_d   = ss_s;
        state_d     = state_q;
        shreg_d     = shreg_q;
        rxbuf_d     = rxbuf_q;
        rx_data_d   = rx_data_q;
        bit_cnt_d   = bit_cnt_q;
        first_d     = first_q;
        reload_d    = reload_q;
        done_d      = 1'b0;
        rx_valid_d  = rx_valid_q;
        overrun_d   = overrun_q;

        // done_q marks the cycle a byte completes; it beats a same-cycle ack
        if (done_q)
            rx_valid_d = 1'b1;
        else if (rx_ack && rx_valid_q)
            rx_valid_d = 1'b0;

`ifdef SPI_SLAVE_OVERRUN_EN
        if (done_q && rx_valid_q && !rx_ack)
            overrun_d = 1'b1;
        else if (rx_ack && !done_q)
            overrun_d = 1'b0;
`else
        overrun_d = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    state_d   = SHIFT;
                    bit_cnt_d = '0;
                    first_d   = 1'b1;
                    reload_d  = 1'b0;
                    if (DAISY == 0)
                        shreg_d = tx_data;
                end
            end
            SHIFT: begin
                if (ss_rise) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    reload_d  = 1'b0;
                end else begin
                    if (lead || trail)
                        first_d = 1'b0;
                    if (sample_edge) begin
                        rxbuf_d   = {rxbuf_q[6:0], mosi_s};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rx_data_d = {rxbuf_q[6:0], mosi_s};
                            done_d    = 1'b1;
                            if (DAISY == 0)
                                reload_d = 1'b1;
                        end
                    end
                    // with cpha=1 the MSB is already on miso before the first edge
                    if (shift_edge && !(first_q && cpha)) begin
                        if (reload_q) begin
                            shreg_d  = tx_data;
                            reload_d = 1'b0;
                        end else begin
                            shreg_d = {shreg_q[6:0], (DAISY != 0) ? rxbuf_q[0] : 1'b0};
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == SHIFT);
        miso_d = (state_d == SHIFT) ? shreg_d[7] : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sclk_sync_q <= '0;
            ss_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_hist_q <= 1'b0;
            ss_hist_q   <= 1'b0;
            state_q     <= IDLE;
            shreg_q     <= '0;
            rxbuf_q     <= '0;
            rx_data_q   <= '0;
            bit_cnt_q   <= '0;
            first_q     <= 1'b0;
            reload_q    <= 1'b0;
            done_q      <= 1'b0;
            rx_valid_q  <= 1'b0;
            miso_q      <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            ss_sync_q   <= ss_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_hist_q <= sclk_hist_d;
            ss_hist_q   <= ss_hist_d;
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            rxbuf_q     <= rxbuf_d;
            rx_data_q   <= rx_data_d;
            bit_cnt_q   <= bit_cnt_d;
            first_q     <= first_d;
            reload_q    <= reload_d;
            done_q      <= done_d;
            rx_valid_q  <= rx_valid_d;
            miso_q      <= miso_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
        end
    end

    assign miso     = miso_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = busy_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: a DAISY=0 and a DAISY=1 instance share one SPI master model.
module tb_spi_slave_rx;
    localparam int HP = 8;

    logic       clk = 1'b0, rst = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       sclk = 1'b0, ss_n = 1'b1, mosi = 1'b0, rx_ack = 1'b0;
    logic [7:0] tx_data = 8'd0;
    logic       miso0, miso1, rx_valid0, rx_valid1, busy0, busy1, overrun0, overrun1;
    logic [7:0] rx_data0, rx_data1;

    int         n_tests = 0, n_fail = 0;
    logic [7:0] tx_bytes [4];
    logic [31:0] got0, got1, exp0, exp1;
    logic [7:0] dm = 8'd0;
    logic       first_pre = 1'b0;
    bit         auto_ack = 1'b1, ack_req = 1'b0, lat_chk = 1'b0, ack_at_done = 1'b0;
    logic [7:0] rxq0[$], rxq1[$];
    logic       exp_ovr;

    spi_slave_rx #(.DAISY(0), .SYNC_STAGES(2)) dut0 (
        .clk(clk), .rst(rst), .mode(mode), .sclk(sclk), .ss_n(ss_n), .mosi(mosi),
        .miso(miso0), .tx_data(tx_data), .rx_data(rx_data0), .rx_valid(rx_valid0),
        .rx_ack(rx_ack), .busy(busy0), .overrun(overrun0));

    spi_slave_rx #(.DAISY(1), .SYNC_STAGES(2)) dut1 (
        .clk(clk), .rst(rst), .mode(mode), .sclk(sclk), .ss_n(ss_n), .mosi(mosi),
        .miso(miso1), .tx_data(tx_data), .rx_data(rx_data1), .rx_valid(rx_valid1),
        .rx_ack(rx_ack), .busy(busy1), .overrun(overrun1));

    always #5 clk = ~clk;

    // Consumer: drives rx_ack mid-cycle, either auto-acking or on request.
    initial begin : ack_mon
        forever begin
            @(posedge clk);
            #2;
            if (auto_ack && rx_valid0 && !rx_ack) begin
                rxq0.push_back(rx_data0);
                rxq1.push_back(rx_data1);
                rx_ack = 1'b1;
            end else begin
                rx_ack = ack_req;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic hp();
        repeat (HP) @(negedge clk);
    endtask

    // Master frame; live=0 means the responder is expected to stay idle.
    task automatic spi_frame(input logic [1:0] m, input int nbits, input bit raise_ss, input bit live);
        logic b, pb;
        got0 = '0; got1 = '0; exp0 = '0; exp1 = '0; pb = 1'b0;
        @(negedge clk);
        mode = m; sclk = m[1];
        hp();
        ss_n = 1'b0;
        hp();
        n_tests++;
        if (busy0 !== live) begin
            n_fail++; $display("FAIL busy_at_start: got %b expected %b", busy0, live);
        end
        for (int i = 0; i < nbits; i++) begin
            b = tx_bytes[i/8][7-(i%8)];
            if (live) begin
                if (m[0] && i > 0) dm = {dm[6:0], pb};
                exp0 = {exp0[30:0], tx_data[7-(i%8)]};
                exp1 = {exp1[30:0], dm[7]};
                if (!m[0]) dm = {dm[6:0], b};
            end
            pb = b;
            if (!m[0]) begin
                mosi = b;
                hp();
            end else begin
                if (i == 0) first_pre = miso0;
                sclk = ~m[1];
                mosi = b;
                hp();
            end
            got0 = {got0[30:0], miso0};
            got1 = {got1[30:0], miso1};
            sclk = m[0] ? m[1] : ~m[1];
            if (i % 8 == 7) begin
                repeat (2) @(negedge clk);
                if (ack_at_done) ack_req = 1'b1;
                @(negedge clk);
                ack_req = 1'b0;
                if (lat_chk) begin
                    n_tests++;
                    if (rx_valid0 !== 1'b0) begin
                        n_fail++; $display("FAIL latency_early: rx_valid got %b expected 0", rx_valid0);
                    end
                end
                @(negedge clk);
                if (lat_chk) begin
                    n_tests++;
                    if (rx_valid0 !== 1'b1) begin
                        n_fail++; $display("FAIL latency_on_time: rx_valid got %b expected 1", rx_valid0);
                    end
                end
                if (ack_at_done) begin
                    n_tests++;
                    if (rx_valid0 !== 1'b1 || rx_data0 !== tx_bytes[i/8]) begin
                        n_fail++;
                        $display("FAIL ack_collision: valid %b data %h expected valid 1 data %h",
                                 rx_valid0, rx_data0, tx_bytes[i/8]);
                    end
                end
                repeat (HP-4) @(negedge clk);
            end else begin
                hp();
            end
            if (!m[0]) sclk = m[1];
        end
        hp();
        if (raise_ss) begin
            ss_n = 1'b1;
            hp();
        end
        n_tests++;
        if (got0 !== exp0) begin
            n_fail++; $display("FAIL miso_local: got %h expected %h", got0, exp0);
        end
        n_tests++;
        if (got1 !== exp1) begin
            n_fail++; $display("FAIL miso_daisy: got %h expected %h", got1, exp1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (4) @(negedge clk);
        n_tests++;
        if ({miso0, miso1, rx_data0, rx_valid0, busy0, overrun0} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_values: miso %b/%b rx_data %h valid %b busy %b ovr %b expected all 0",
                     miso0, miso1, rx_data0, rx_valid0, busy0, overrun0);
        end
        rst = 1'b1;
        dm = 8'd0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_mode0();
        auto_ack = 1'b1; rxq0.delete(); rxq1.delete();
        tx_data = 8'hA5; tx_bytes[0] = 8'h3C;
        lat_chk = 1'b1;
        spi_frame(2'd0, 8, 1'b1, 1'b1);
        lat_chk = 1'b0;
        repeat (4) @(negedge clk);
        n_tests++;
        if (rxq0.size() != 1 || rxq0[0] !== 8'h3C) begin
            n_fail++; $display("FAIL mode0_rx: got %0d bytes first %h expected 1 byte 3c",
                               rxq0.size(), (rxq0.size() > 0) ? rxq0[0] : 8'hxx);
        end
        n_tests++;
        if (got0[7:0] !== 8'hA5) begin
            n_fail++; $display("FAIL mode0_miso: got %h expected a5", got0[7:0]);
        end
        n_tests++;
        if (busy0 !== 1'b0) begin
            n_fail++; $display("FAIL mode0_busy_end: got %b expected 0", busy0);
        end
    endtask

    task automatic test_modes();
        for (int m = 1; m < 4; m++) begin
            rxq0.delete(); rxq1.delete();
            tx_data = 8'($urandom) ^ ((m == 2) ? 8'h80 : 8'h00);
            tx_bytes[0] = 8'h81;
            spi_frame(2'(m), 8, 1'b1, 1'b1);
            repeat (4) @(negedge clk);
            n_tests++;
            if (rxq0.size() != 1 || rxq0[0] !== 8'h81) begin
                n_fail++; $display("FAIL mode%0d_rx: got %0d bytes first %h expected 1 byte 81",
                                   m, rxq0.size(), (rxq0.size() > 0) ? rxq0[0] : 8'hxx);
            end
            if (m % 2 == 1) begin
                n_tests++;
                if (first_pre !== tx_data[7]) begin
                    n_fail++; $display("FAIL mode%0d_msb_early: got %b expected %b", m, first_pre, tx_data[7]);
                end
            end
        end
    endtask

    task automatic test_daisy();
        @(negedge clk); rst = 1'b0; @(negedge clk); rst = 1'b1; dm = 8'd0;
        repeat (4) @(negedge clk);
        rxq0.delete(); rxq1.delete();
        tx_data = 8'h00; tx_bytes[0] = 8'h12; tx_bytes[1] = 8'h34;
        spi_frame(2'd0, 16, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        n_tests++;
        if (got1[15:0] !== 16'h0012) begin
            n_fail++; $display("FAIL daisy_miso: got %h expected 0012", got1[15:0]);
        end
        n_tests++;
        if (rxq1.size() != 2 || rxq1[0] !== 8'h12 || rxq1[1] !== 8'h34) begin
            n_fail++; $display("FAIL daisy_rx: got %0d bytes expected 12,34", rxq1.size());
        end
    endtask

    task automatic test_abort();
        rxq0.delete(); rxq1.delete();
        tx_bytes[0] = 8'hFF;
        spi_frame(2'd0, 5, 1'b1, 1'b1);
        repeat (8) @(negedge clk);
        n_tests++;
        if (rxq0.size() != 0 || rx_valid0 !== 1'b0 || busy0 !== 1'b0) begin
            n_fail++; $display("FAIL abort: got %0d bytes valid %b busy %b expected 0 0 0",
                               rxq0.size(), rx_valid0, busy0);
        end
        tx_bytes[0] = 8'h55;
        spi_frame(2'd0, 8, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        n_tests++;
        if (rxq0.size() != 1 || rxq0[0] !== 8'h55) begin
            n_fail++; $display("FAIL abort_recover: got %0d bytes expected 1 byte 55", rxq0.size());
        end
    endtask

    task automatic test_overrun();
`ifdef SPI_SLAVE_OVERRUN_EN
        exp_ovr = 1'b1;
`else
        exp_ovr = 1'b0;
`endif
        auto_ack = 1'b0;
        tx_bytes[0] = 8'hA1; tx_bytes[1] = 8'hB2;
        spi_frame(2'd0, 16, 1'b1, 1'b1);
        n_tests++;
        if (rx_valid0 !== 1'b1 || rx_data0 !== 8'hB2 || overrun0 !== exp_ovr) begin
            n_fail++; $display("FAIL overrun_set: valid %b data %h ovr %b expected 1 b2 %b",
                               rx_valid0, rx_data0, overrun0, exp_ovr);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); ack_req = 1'b1;
            @(negedge clk); ack_req = 1'b0;
            repeat (3) @(negedge clk);
            n_tests++;
            if (rx_valid0 !== 1'b0 || overrun0 !== 1'b0 || rx_data0 !== 8'hB2) begin
                n_fail++; $display("FAIL overrun_ack%0d: valid %b ovr %b data %h expected 0 0 b2",
                                   k, rx_valid0, overrun0, rx_data0);
            end
        end
        auto_ack = 1'b1;
    endtask

    task automatic test_ack_at_done();
        auto_ack = 1'b0; ack_at_done = 1'b1;
        tx_bytes[0] = 8'hC4; tx_bytes[1] = 8'h5D;
        spi_frame(2'd0, 16, 1'b1, 1'b1);
        ack_at_done = 1'b0;
        n_tests++;
        if (rx_valid0 !== 1'b1 || rx_data0 !== 8'h5D || overrun0 !== 1'b0) begin
            n_fail++; $display("FAIL ack_done_end: valid %b data %h ovr %b expected 1 5d 0",
                               rx_valid0, rx_data0, overrun0);
        end
        @(negedge clk); ack_req = 1'b1;
        @(negedge clk); ack_req = 1'b0;
        repeat (3) @(negedge clk);
        auto_ack = 1'b1;
    endtask

    task automatic test_reset_midframe();
        logic [7:0] v;
        auto_ack = 1'b0;
        tx_data = 8'h9E; tx_bytes[0] = 8'hE7;
        spi_frame(2'd0, 8, 1'b1, 1'b1);
        tx_bytes[0] = 8'hAB;
        spi_frame(2'd0, 4, 1'b0, 1'b1);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({miso0, miso1, rx_data0, rx_valid0, busy0, overrun0} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_midframe: miso %b/%b rx_data %h valid %b busy %b ovr %b expected all 0",
                     miso0, miso1, rx_data0, rx_valid0, busy0, overrun0);
        end
        rst = 1'b1; dm = 8'd0;
        auto_ack = 1'b1; rxq0.delete(); rxq1.delete();
        tx_bytes[0] = 8'h6B;
        spi_frame(2'd0, 8, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        n_tests++;
        if (rxq0.size() != 0 || rx_valid0 !== 1'b0) begin
            n_fail++; $display("FAIL reset_ss_low: got %0d bytes valid %b expected 0 0", rxq0.size(), rx_valid0);
        end
        ss_n = 1'b1;
        hp();
        v = 8'($urandom);
        tx_bytes[0] = v;
        spi_frame(2'd0, 8, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        n_tests++;
        if (rxq0.size() != 1 || rxq0[0] !== v) begin
            n_fail++; $display("FAIL reset_resume: got %0d bytes expected 1 byte %h", rxq0.size(), v);
        end
    endtask

    task automatic test_random();
        logic [1:0] m;
        int nb, nbits;
        auto_ack = 1'b1;
        for (int f = 0; f < 20; f++) begin
            m = 2'($urandom_range(0, 3));
            nb = int'($urandom_range(1, 3));
            tx_data = 8'($urandom);
            for (int k = 0; k < 4; k++) tx_bytes[k] = 8'($urandom);
            nbits = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, nb*8 - 1)) : nb*8;
            rxq0.delete(); rxq1.delete();
            spi_frame(m, nbits, 1'b1, 1'b1);
            repeat (4) @(negedge clk);
            n_tests++;
            if (rxq0.size() != nbits/8 || rxq1.size() != nbits/8) begin
                n_fail++; $display("FAIL rand_count f%0d: got %0d/%0d bytes expected %0d",
                                   f, rxq0.size(), rxq1.size(), nbits/8);
            end else begin
                for (int k = 0; k < nbits/8; k++) begin
                    n_tests++;
                    if (rxq0[k] !== tx_bytes[k] || rxq1[k] !== tx_bytes[k]) begin
                        n_fail++; $display("FAIL rand_rx f%0d b%0d: got %h/%h expected %h",
                                           f, k, rxq0[k], rxq1[k], tx_bytes[k]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_modes();
        test_daisy();
        test_abort();
        test_overrun();
        test_ack_at_done();
        test_reset_midframe();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave_rx.md
Name: spi_slave_rx

Overview:
- SPI responder (slave) for the SPI chain; the receiving end of the 8-bit MSB-first SPI master.
- Oversamples sclk/ss_n/mosi on its own system clock, then recovers received bytes and drives miso with either a local transmit byte or daisy-chain pass-through.
- One instance per chain position; rx bytes go to local logic through a valid/ack handshake.

Parameters:
- DAISY, 0, 1 = miso carries mosi delayed by 8 bits (chain pass-through), 0 = miso carries tx_data.
- SYNC_STAGES, 2, synchronizer depth on sclk, ss_n, mosi (legal 2..3).

Ports:
- clk  in  1  system clock; must be ≥4× sclk frequency.
- rst  in  1  synchronous, active-low reset.
- mode  in  2  {cpol,cpha}; static while ss_n low.
- sclk  in  1  SPI clock from master (asynchronous).
- ss_n  in  1  chip select, active-low (system decodes master ss into per-slave ss_n).
- mosi  in  1  serial data in.
- miso  out  1  serial data out.
- tx_data  in  8  byte to return; sampled at frame/byte start when DAISY=0.
- rx_data  out  8  last complete received byte.
- rx_valid  out  1  high while rx_data is unconsumed.
- rx_ack  in  1  consumer accepts rx_data.
- busy  out  1  high while in SHIFT state.
- overrun  out  1  sticky byte-lost flag (see Optional Feature).

Behaviour:
- Reset values: miso=0, rx_data=0, rx_valid=0, busy=0, overrun=0, shreg=0, bit_cnt=0, state=IDLE.
- Synchronizers: sclk, ss_n and mosi each pass SYNC_STAGES flops, plus one history flop on sclk and ss_n for edge detection.
  - lead = sclk edge away from cpol; trail = edge back to cpol.
  - sample_edge = lead if cpha=0, else trail; shift_edge = the other.
- States:
  - IDLE: miso=0, busy=0.
    - Synced ss_n falling → SHIFT.
    - Same cycle: bit_cnt=0, first=1, and shreg=tx_data if DAISY=0 (shreg unchanged if DAISY=1).
  - SHIFT: busy=1, miso=shreg[7] (registered, no combinational path from inputs).
    - sample_edge: rxbuf={rxbuf[6:0],mosi_sync}; bit_cnt+1.
    - shift_edge: shreg={shreg[6:0], DAISY ? mosi_sampled : 0}.
      - Suppressed when first=1 and cpha=1, since MSB is already presented; first clears on any edge.
    - On the 8th sample_edge (bit_cnt 7→0 wrap):
      - rx_data<=completed byte (rxbuf with last bit), rx_valid<=1 next cycle.
      - DAISY=0: shreg reloads tx_data at the next shift_edge instead of shifting, so multi-byte frames carry a fresh byte each 8 bits.
    - Synced ss_n rising → IDLE in the next cycle, from any bit position.
      - Partial byte discarded; rx_valid not asserted; bit_cnt cleared.
- Handshake:
  - rx_valid clears the cycle after rx_ack while rx_valid=1.
  - A new byte completing on the same cycle as rx_ack wins: rx_valid stays 1 with new data.
  - rx_ack while rx_valid=0 is ignored.
- Latency: rx_valid rises SYNC_STAGES+2 clk cycles after the 8th sample sclk edge at the pins.
- sclk edges while ss_n high are ignored.
- Mode change while SHIFT: undefined; bench must not do it.
- Reset asserted mid-frame returns all state to reset values on that clock edge.
  - After reset release with ss_n already low, the block waits in IDLE for a fresh ss_n fall.

Optional Feature:
- Macro SPI_SLAVE_OVERRUN_EN.
- Defined: a byte completing while rx_valid=1 with no rx_ack that cycle sets overrun=1; rx_data is overwritten with the new byte.
  - overrun stays set until reset, or until rx_ack is asserted in a cycle when no byte completes.
- Not defined: overrun tied 0; rx_data overwritten silently.

Test Plan:
- Mode 0, DAISY=0, tx_data=8'hA5, master sends 8'h3C with ack → rx_data=8'h3C, one rx_valid; miso bits 1,0,1,0,0,1,0,1.
- Modes 1, 2, 3 each, master sends 8'h81 → rx_data=8'h81; for cpha=1 miso MSB stable before first trail edge.
- DAISY=1, two back-to-back bytes 8'h12,8'h34 in one ss_n frame → miso carries 8'h00 then 8'h12; rx_data 8'h12 then 8'h34.
- ss_n raised after 5 bits of 8'hFF → no rx_valid, busy drops; next full byte 8'h55 received as 8'h55.
- Overrun (macro on): two bytes, no ack → overrun=1, rx_data=second byte; ack → overrun=0, rx_valid=0. Macro off → overrun stays 0.
- Reset pulse (rst=0 one cycle) after bit 4 → all outputs 0; with ss_n held low no reception until ss_n toggles high then low.
